// File: rtl/train_pkg.sv
// Shared types and constants for the train-dispatch serial protocol (sender and checker sides).
package train_pkg;

  localparam int unsigned CAR_W    = 4;
  localparam int unsigned MAX_CARS = 10;
  localparam int unsigned MIN_CARS = 3;

  localparam logic OP_PUSH = 1'b1;
  localparam logic OP_POP  = 1'b0;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StCheck,
    StSend,
    StErr
  } train_state_e;

endpackage

// File: rtl/train_sender_if.sv
// Input op stream and output departure burst of the train sender.
interface train_sender_if;
  import train_pkg::*;

  logic             in_valid;
  logic [CAR_W-1:0] in_data;
  logic             out_valid;
  logic [CAR_W-1:0] out_data;
  logic             err;

  modport master (
    output in_valid,
    output in_data,
    input  out_valid,
    input  out_data,
    input  err
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output out_valid,
    output out_data,
    output err
  );

endinterface

// File: rtl/train_stack.sv
// Depth-deep LIFO of car numbers; ignores pop when empty and push when full.
module train_stack
  import train_pkg::*;
#(
  parameter int unsigned Depth = MAX_CARS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [CAR_W-1:0] data_i,
  output logic [CAR_W-1:0] top_o,
  output logic             empty_o,
  output logic [CAR_W-1:0] count_o
);

  localparam logic [CAR_W-1:0] DepthC = CAR_W'(Depth);

  logic [CAR_W-1:0] mem_q [Depth];
  logic [CAR_W-1:0] mem_d [Depth];
  logic [CAR_W-1:0] cnt_q, cnt_d;
  logic [CAR_W-1:0] top_idx;

  assign top_idx = cnt_q - 1'b1;
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign top_o   = empty_o ? '0 : mem_q[top_idx];

  always_comb begin
    mem_d = mem_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      for (int i = 0; i < int'(Depth); i++) mem_d[i] = '0;
      cnt_d = '0;
    end else if (push_i && (cnt_q < DepthC)) begin
      mem_d[cnt_q] = data_i;
      cnt_d        = cnt_q + 1'b1;
    end else if (pop_i && !empty_o) begin
      cnt_d = top_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/train_sender.sv
// Train-dispatch transmitter: replays push/pop ops on a station stack and sends N plus departures.
// Legality checking and the err pulse exist only when TRAIN_SENDER_ERR_EN is defined.
module train_sender
#(
  parameter int unsigned MAX_CARS = train_pkg::MAX_CARS,
  parameter int unsigned MIN_CARS = train_pkg::MIN_CARS
) (
  input  logic           clk,
  input  logic           rst,
  train_sender_if.slave  bus
);
  import train_pkg::*;

  if (MIN_CARS > MAX_CARS || MAX_CARS > 15) begin : g_bad_cfg
    $error("train_sender: need MIN_CARS <= MAX_CARS <= 15");
  end

  localparam logic [CAR_W-1:0] MaxC = CAR_W'(MAX_CARS);

  train_state_e     state_q, state_d;
  logic [CAR_W-1:0] n_q, n_d;
  logic [4:0]       nxt_q, nxt_d;
  logic [CAR_W-1:0] dc_q, dc_d;
  logic [4:0]       oc_q, oc_d;
  logic [CAR_W-1:0] si_q, si_d;
  logic [CAR_W-1:0] dep_q [MAX_CARS];
  logic [CAR_W-1:0] dep_d [MAX_CARS];
  logic             out_valid_q, out_valid_d;
  logic [CAR_W-1:0] out_data_q, out_data_d;
`ifdef TRAIN_SENDER_ERR_EN
  logic             bad_q, bad_d;
  logic             err_q, err_d;
  logic             legal;
`endif

  logic             stk_clr, stk_push, stk_pop, stk_empty;
  logic [CAR_W-1:0] stk_top, stk_count;
  logic [CAR_W-1:0] n_lim;
  logic             push_ok;

  train_stack #(
    .Depth (MAX_CARS)
  ) u_stack (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (stk_clr),
    .push_i  (stk_push),
    .pop_i   (stk_pop),
    .data_i  (nxt_q[CAR_W-1:0]),
    .top_o   (stk_top),
    .empty_o (stk_empty),
    .count_o (stk_count)
  );

  // Clamped N bounds the stack and dep buffer; the raw N is still what gets sent.
  assign n_lim   = (n_q > MaxC) ? MaxC : n_q;
  assign push_ok = (nxt_q <= {1'b0, n_lim}) && (stk_count < MaxC);

`ifdef TRAIN_SENDER_ERR_EN
  assign legal = !bad_q && (n_q >= CAR_W'(MIN_CARS)) && (n_q <= MaxC) &&
                 (oc_q == {n_q, 1'b0}) && (stk_count == '0) && (dc_q == n_q);
`endif

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    nxt_d       = nxt_q;
    dc_d        = dc_q;
    oc_d        = oc_q;
    si_d        = si_q;
    dep_d       = dep_q;
    out_valid_d = 1'b0;
    out_data_d  = '0;
    stk_clr     = 1'b0;
    stk_push    = 1'b0;
    stk_pop     = 1'b0;
`ifdef TRAIN_SENDER_ERR_EN
    bad_d       = bad_q;
    err_d       = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          n_d     = bus.in_data;
          nxt_d   = 5'd1;
          dc_d    = '0;
          oc_d    = '0;
          stk_clr = 1'b1;
          for (int i = 0; i < int'(MAX_CARS); i++) dep_d[i] = '0;
`ifdef TRAIN_SENDER_ERR_EN
          bad_d   = 1'b0;
`endif
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (bus.in_valid) begin
          if (oc_q != 5'd31) oc_d = oc_q + 5'd1;
`ifdef TRAIN_SENDER_ERR_EN
          if (!bad_q) begin
`else
          begin
`endif
            if (bus.in_data[0] == OP_PUSH) begin
              if (push_ok) begin
                stk_push = 1'b1;
                nxt_d    = nxt_q + 5'd1;
              end
`ifdef TRAIN_SENDER_ERR_EN
              else bad_d = 1'b1;
`endif
            end else if (!stk_empty) begin
              stk_pop     = 1'b1;
              dep_d[dc_q] = stk_top;
              dc_d        = dc_q + 1'b1;
            end
`ifdef TRAIN_SENDER_ERR_EN
            else bad_d = 1'b1;
`endif
          end
        end else begin
          state_d = StCheck;
        end
      end
      StCheck: begin
`ifdef TRAIN_SENDER_ERR_EN
        if (legal) begin
`else
        begin
`endif
          out_valid_d = 1'b1;
          out_data_d  = n_q;
          si_d        = '0;
          state_d     = StSend;
        end
`ifdef TRAIN_SENDER_ERR_EN
        else begin
          err_d   = 1'b1;
          state_d = StErr;
        end
`endif
      end
      StSend: begin
        // si_q is the beat on the wire now; beat si_q+1 carries dep[si_q].
        if (si_q == n_q) begin
          state_d = StIdle;
        end else begin
          si_d        = si_q + 1'b1;
          out_valid_d = 1'b1;
          out_data_d  = (si_q < MaxC) ? dep_q[si_q] : '0;
        end
      end
`ifdef TRAIN_SENDER_ERR_EN
      StErr: state_d = StIdle;
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      n_q         <= '0;
      nxt_q       <= '0;
      dc_q        <= '0;
      oc_q        <= '0;
      si_q        <= '0;
      dep_q       <= '{default: '0};
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
`ifdef TRAIN_SENDER_ERR_EN
      bad_q       <= 1'b0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      nxt_q       <= nxt_d;
      dc_q        <= dc_d;
      oc_q        <= oc_d;
      si_q        <= si_d;
      dep_q       <= dep_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
`ifdef TRAIN_SENDER_ERR_EN
      bad_q       <= bad_d;
      err_q       <= err_d;
`endif
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
`ifdef TRAIN_SENDER_ERR_EN
  assign bus.err       = err_q;
`else
  assign bus.err       = 1'b0;
`endif

endmodule

// File: tb/tb_train_sender.sv
// Directed bench for train_sender: op strings with hand-computed departure bursts.
module tb_train_sender;

  logic clk;
  logic rst;

  train_sender_if bus ();

  train_sender dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  bit ops_q[$];
  int exp_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic ops_alt(input int n);
    ops_q.delete();
    for (int i = 0; i < n; i++) begin
      ops_q.push_back(1'b1);
      ops_q.push_back(1'b0);
    end
  endtask

  task automatic ops_nest(input int n);
    ops_q.delete();
    for (int i = 0; i < n; i++) ops_q.push_back(1'b1);
    for (int i = 0; i < n; i++) ops_q.push_back(1'b0);
  endtask

  // Drives N then ops_q, then checks latency and either the err pulse or the exp_q burst.
  task automatic run_burst(input string tag, input int n, input bit exp_err,
                           input int pulse_at, input int rst_at);
    int lat;
    int idx;
    bit seen;
    bit aborted;
    int got[32];

    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 4'(n);
    foreach (ops_q[i]) begin
      @(negedge clk);
      bus.in_data = {3'b101, ops_q[i]};
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 12) begin
      @(negedge clk);
      lat++;
      if (bus.out_valid || bus.err) seen = 1'b1;
    end
    check_eq({tag, " latency"}, seen ? lat : -1, 2);

    if (exp_err) begin
      check_eq({tag, " err"}, bus.err, 1);
      check_eq({tag, " no out_valid"}, bus.out_valid, 0);
      @(negedge clk);
      check_eq({tag, " err one cycle"}, bus.err, 0);
      check_eq({tag, " still no out_valid"}, bus.out_valid, 0);
      return;
    end

    check_eq({tag, " err low"}, bus.err, 0);
    idx     = 0;
    aborted = 1'b0;
    while (bus.out_valid && idx < 32) begin
      got[idx] = int'(bus.out_data);
      if (idx == rst_at) begin
        rst = 1'b1;
        #1;
        check_eq({tag, " rst out_valid"}, bus.out_valid, 0);
        check_eq({tag, " rst out_data"}, bus.out_data, 0);
        check_eq({tag, " rst err"}, bus.err, 0);
        @(negedge clk);
        rst     = 1'b0;
        aborted = 1'b1;
        idx++;
        break;
      end
      if (idx == pulse_at) begin
        bus.in_valid = 1'b1;
        bus.in_data  = 4'd3;
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      idx++;
    end

    if (!aborted) begin
      check_eq({tag, " beat count"}, idx, exp_q.size());
      check_eq({tag, " data idle"}, bus.out_data, 0);
    end
    for (int i = 0; i < idx && i < exp_q.size(); i++)
      check_eq($sformatf("%s beat%0d", tag, i), got[i], exp_q[i]);
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    int act;
    act = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.out_valid || bus.err) act++;
    end
    check_eq({tag, " quiet"}, act, 0);
  endtask

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(negedge clk);
    check_eq("reset out_valid", bus.out_valid, 0);
    check_eq("reset out_data", bus.out_data, 0);
    check_eq("reset err", bus.err, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    ops_alt(3);
    exp_q = '{3, 1, 2, 3};
    run_burst("n3 alt", 3, 1'b0, -1, -1);

    ops_nest(3);
    exp_q = '{3, 3, 2, 1};
    run_burst("n3 nest", 3, 1'b0, -1, -1);

    ops_alt(4);
    ops_q.push_front(1'b0);
`ifdef TRAIN_SENDER_ERR_EN
    exp_q = '{};
    run_burst("n4 pop first", 4, 1'b1, -1, -1);
`else
    exp_q = '{4, 1, 2, 3, 4};
    run_burst("n4 pop first", 4, 1'b0, -1, -1);
`endif

    ops_alt(2);
`ifdef TRAIN_SENDER_ERR_EN
    exp_q = '{};
    run_burst("n2", 2, 1'b1, -1, -1);
`else
    exp_q = '{2, 1, 2};
    run_burst("n2", 2, 1'b0, -1, -1);
`endif

    ops_nest(11);
`ifdef TRAIN_SENDER_ERR_EN
    exp_q = '{};
    run_burst("n11", 11, 1'b1, -1, -1);
`else
    exp_q = '{11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0};
    run_burst("n11", 11, 1'b0, -1, -1);
`endif

    ops_nest(10);
    exp_q = '{10, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1};
    run_burst("n10 pulse", 10, 1'b0, 3, -1);
    expect_quiet("n10 pulse", 6);

    ops_alt(5);
    exp_q = '{5, 1, 2, 3, 4, 5};
    run_burst("n5 reset", 5, 1'b0, -1, 2);
    expect_quiet("after reset", 4);

    ops_nest(3);
    exp_q = '{3, 3, 2, 1};
    run_burst("n3 after reset", 3, 1'b0, -1, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
